// File: rtl/jogador_automatico.sv
// Self-play responder for the memory game: captures each LED sequence and replays it on the buttons.
// Registered outputs, one-cycle decisions; no backpressure (the game's leds/result lines are only observed).
module jogador_automatico #(
  parameter int MAX_NIVEL    = 16,
  parameter int QUIET_CYCLES = 8,
  parameter int PRESS_CYCLES = 3,
  parameter int GAP_CYCLES   = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic       errar,
  input  logic [3:0] leds,
  input  logic       ganhou,
  input  logic       perdeu,
  input  logic       pronto,
  output logic       jogar,
  output logic [3:0] botoes,
  output logic       vitoria,
  output logic       derrota,
  output logic       estouro,
  output logic       ocupado,
  output logic [3:0] db_estado,
  output logic [4:0] db_contagem
);

  localparam int          AW        = (MAX_NIVEL > 1) ? $clog2(MAX_NIVEL) : 1;
  localparam logic [4:0]  MAX_C     = 5'(MAX_NIVEL);
  localparam logic [15:0] QUIET_FIM = 16'(QUIET_CYCLES - 1);
  localparam logic [7:0]  PRESS_FIM = 8'(PRESS_CYCLES - 1);
  localparam logic [7:0]  GAP_FIM   = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    INICIAL   = 3'd0,
    JOGAR     = 3'd1,
    OBSERVA   = 3'd2,
    PRESSIONA = 3'd3,
    SOLTA     = 3'd4,
    FIM       = 3'd6,
    ESTOURO   = 3'd7
  } estado_t;

  estado_t     estado;
  logic [3:0]  mem [MAX_NIVEL];
  logic [3:0]  leds_ant;
  logic [4:0]  cnt;
  logic [4:0]  idx;
  logic [4:0]  idx_prox;
  logic [15:0] quieto;
  logic [7:0]  tempo;
  logic        evento;
  logic        resultado;
  logic [3:0]  tecla_ini;
  logic [3:0]  tecla_prox;

  function automatic logic [3:0] girar(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  // Button value for the first press of a round and for the press after the current one;
  // the deliberate mistake only ever lands on the final press.
  always_comb begin
    evento     = (leds != 4'd0) && (leds != leds_ant);
    resultado  = ganhou | perdeu | pronto;
    idx_prox   = idx + 5'd1;
    tecla_ini  = mem[0];
    if (errar && cnt == 5'd1)
      tecla_ini = girar(mem[0]);
    tecla_prox = mem[idx_prox[AW-1:0]];
    if (errar && idx_prox == cnt - 5'd1)
      tecla_prox = girar(mem[idx_prox[AW-1:0]]);
  end

  assign ocupado     = (estado != INICIAL);
  assign db_estado   = {1'b0, estado};
  assign db_contagem = cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado   <= INICIAL;
      jogar    <= 1'b0;
      botoes   <= 4'd0;
      vitoria  <= 1'b0;
      derrota  <= 1'b0;
      estouro  <= 1'b0;
      leds_ant <= 4'd0;
      cnt      <= 5'd0;
      idx      <= 5'd0;
      quieto   <= 16'd0;
      tempo    <= 8'd0;
    end else begin
      leds_ant <= leds;
      jogar    <= 1'b0;
      case (estado)
        INICIAL: begin
          botoes <= 4'd0;
          if (habilita) begin
            estado <= JOGAR;
            jogar  <= 1'b1;
          end
        end
        JOGAR: begin
          if (!habilita) begin
            estado <= INICIAL;
            botoes <= 4'd0;
          end else begin
            cnt     <= 5'd0;
            quieto  <= 16'd0;
            vitoria <= 1'b0;
            derrota <= 1'b0;
            estado  <= OBSERVA;
          end
        end
        OBSERVA, PRESSIONA, SOLTA: begin
          // Abort beats a game result, which beats everything else.
          if (!habilita) begin
            estado <= INICIAL;
            botoes <= 4'd0;
          end else if (resultado) begin
            estado  <= FIM;
            botoes  <= 4'd0;
            vitoria <= ganhou;
            derrota <= perdeu;
          end else if (estado == OBSERVA) begin
            if (evento) begin
              if (cnt < MAX_C) begin
                mem[cnt[AW-1:0]] <= leds;
                cnt              <= cnt + 5'd1;
                quieto           <= 16'd0;
              end else begin
                estado  <= ESTOURO;
                estouro <= 1'b1;
                botoes  <= 4'd0;
              end
            end else if (leds == 4'd0 && cnt != 5'd0) begin
              if (quieto == QUIET_FIM) begin
                quieto <= 16'd0;
                idx    <= 5'd0;
                tempo  <= 8'd0;
                botoes <= tecla_ini;
                estado <= PRESSIONA;
              end else begin
                quieto <= quieto + 16'd1;
              end
            end else if (cnt == 5'd0) begin
              quieto <= 16'd0;
            end
          end else if (estado == PRESSIONA) begin
            if (tempo == PRESS_FIM) begin
              tempo  <= 8'd0;
              botoes <= 4'd0;
              estado <= SOLTA;
            end else begin
              tempo <= tempo + 8'd1;
            end
          end else begin
            if (tempo == GAP_FIM) begin
              tempo <= 8'd0;
              idx   <= idx_prox;
              if (idx_prox == cnt) begin
                cnt    <= 5'd0;
                quieto <= 16'd0;
                estado <= OBSERVA;
              end else begin
                botoes <= tecla_prox;
                estado <= PRESSIONA;
              end
            end else begin
              tempo <= tempo + 8'd1;
            end
          end
        end
        FIM: begin
          botoes <= 4'd0;
          if (!habilita)
            estado <= INICIAL;
        end
        ESTOURO: begin
          botoes <= 4'd0;
          if (!habilita) begin
            estado  <= INICIAL;
            estouro <= 1'b0;
          end
        end
        default: begin
          estado <= INICIAL;
          botoes <= 4'd0;
        end
      endcase
    end
  end

endmodule
